// File: rtl/barrier_agent_pkg.sv
// Shared definitions for the multilevel barrier and its per-level agents.
package barrier_pkg;

  localparam int BARRIER_COUNTER_BITS = 4;
  localparam int MAX_AHEAD_LIMIT      = 2**BARRIER_COUNTER_BITS - 1;
  localparam int CMD_DATA_W           = 32;

  typedef struct packed {
    logic                  barrier;
    logic [CMD_DATA_W-1:0] payload;
  } cmd_t;

  typedef enum logic {
    ST_RUN,
    ST_BLOCKED
  } agent_state_e;

endpackage

// File: rtl/barrier_agent_cmd_slot.sv
// One-entry registered valid/ready stage; a load may coincide with a drain.
module cmd_slot
  import barrier_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/barrier_agent.sv
// Per-level barrier client: turns barrier markers into wait pulses and fences
// later commands against the number of unreleased waits.
module barrier_agent
  import barrier_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MAX_AHEAD = 1
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 in_cmd_valid,
  output logic                                 in_cmd_ready,
  input  logic [DATA_W-1:0]                    in_cmd_data,
  input  logic                                 in_cmd_barrier,
  output logic                                 out_cmd_valid,
  input  logic                                 out_cmd_ready,
  output logic [DATA_W-1:0]                    out_cmd_data,
  output logic                                 out_wait,
  input  logic                                 in_release,
  output logic [$clog2(MAX_AHEAD+1)-1:0]       out_outstanding,
  output logic                                 out_blocked,
  output logic                                 out_error
);

  localparam int CNT_W = $clog2(MAX_AHEAD + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_AHEAD);

  if (MAX_AHEAD < 1 || MAX_AHEAD > MAX_AHEAD_LIMIT) begin : g_range_check
    $error("barrier_agent: MAX_AHEAD=%0d outside 1..%0d", MAX_AHEAD, MAX_AHEAD_LIMIT);
  end

  logic [CNT_W-1:0] outstanding_q;
  logic [CNT_W-1:0] outstanding_d;
  logic             wait_q;
  logic             error_q;
  logic             slot_valid;
  logic             bar_accept;
  logic             data_accept;
  logic             release_ok;
  agent_state_e     state;

  // State is a decode of the counter; error is tracked orthogonally.
  always_comb begin
    state = ST_RUN;
    if (outstanding_q == LIMIT) state = ST_BLOCKED;
  end

  // Ready never looks at in_cmd_valid; a barrier also waits for an empty slot.
  always_comb begin
    in_cmd_ready = 1'b0;
    unique case (state)
      ST_RUN:     in_cmd_ready = in_cmd_barrier ? !slot_valid
                                                : (!slot_valid || out_cmd_ready);
      ST_BLOCKED: in_cmd_ready = 1'b0;
      default:    in_cmd_ready = 1'b0;
    endcase
  end

  always_comb begin
    bar_accept  = in_cmd_valid && in_cmd_ready && in_cmd_barrier;
    data_accept = in_cmd_valid && in_cmd_ready && !in_cmd_barrier;
    release_ok  = in_release && (outstanding_q != '0);
  end

  always_comb begin
    outstanding_d = outstanding_q;
    unique case ({bar_accept, release_ok})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outstanding_q <= '0;
      wait_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      wait_q        <= bar_accept;
      if (in_release && (outstanding_q == '0)) error_q <= 1'b1;
    end
  end

  cmd_slot #(
    .DATA_W (DATA_W)
  ) u_slot (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (data_accept),
    .load_data (in_cmd_data),
    .out_ready (out_cmd_ready),
    .out_valid (slot_valid),
    .out_data  (out_cmd_data)
  );

  assign out_cmd_valid   = slot_valid;
  assign out_wait        = wait_q;
  assign out_outstanding = outstanding_q;
  assign out_blocked     = (state == ST_BLOCKED);
  assign out_error       = error_q;

endmodule

// File: tb/tb_barrier_agent.sv
// Bench for barrier_agent: strict-fence (MAX_AHEAD=1) and run-ahead (MAX_AHEAD=3) instances.
module tb_barrier_agent;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        iv  [2];
  logic        ib  [2];
  logic [31:0] id  [2];
  logic        orr [2];
  logic        rel [2];
  logic        ir  [2];
  logic        ov  [2];
  logic [31:0] od  [2];
  logic        ow  [2];
  logic        ob  [2];
  logic        oe  [2];
  logic [0:0]  os0;
  logic [1:0]  os1;

  int n_chk  = 0;
  int n_pass = 0;
  int waits [2] = '{0, 0};
  logic [31:0] emit0 [$];

  // model state
  bit          m_v [2];
  logic [31:0] m_d [2];
  int          m_o [2];
  bit          m_w [2];
  bit          m_e [2];

  always #5 clk = ~clk;

  barrier_agent #(.DATA_W(32), .MAX_AHEAD(1)) u_strict (
    .clk(clk), .reset_n(reset_n),
    .in_cmd_valid(iv[0]), .in_cmd_ready(ir[0]), .in_cmd_data(id[0]), .in_cmd_barrier(ib[0]),
    .out_cmd_valid(ov[0]), .out_cmd_ready(orr[0]), .out_cmd_data(od[0]),
    .out_wait(ow[0]), .in_release(rel[0]), .out_outstanding(os0),
    .out_blocked(ob[0]), .out_error(oe[0])
  );

  barrier_agent #(.DATA_W(32), .MAX_AHEAD(3)) u_ahead (
    .clk(clk), .reset_n(reset_n),
    .in_cmd_valid(iv[1]), .in_cmd_ready(ir[1]), .in_cmd_data(id[1]), .in_cmd_barrier(ib[1]),
    .out_cmd_valid(ov[1]), .out_cmd_ready(orr[1]), .out_cmd_data(od[1]),
    .out_wait(ow[1]), .in_release(rel[1]), .out_outstanding(os1),
    .out_blocked(ob[1]), .out_error(oe[1])
  );

  function automatic int maxa(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int outs(int i);
    return (i == 0) ? int'(os0) : int'(os1);
  endfunction

  // Model acceptance rule: room below the limit, and a barrier needs everything already handed on.
  function automatic bit m_rdy(int i);
    bit below = m_o[i] < maxa(i);
    if (ib[i]) return below && !m_v[i];
    return below && (!m_v[i] || orr[i]);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        m_v[i] <= 1'b0; m_d[i] <= '0; m_o[i] <= 0; m_w[i] <= 1'b0; m_e[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        automatic bit acc    = iv[i] && m_rdy(i);
        automatic int inc    = (acc && ib[i]) ? 1 : 0;
        automatic int dec    = (rel[i] && m_o[i] > 0) ? 1 : 0;
        if (acc && !ib[i]) begin
          m_v[i] <= 1'b1;
          m_d[i] <= id[i];
        end else if (m_v[i] && orr[i]) begin
          m_v[i] <= 1'b0;
        end
        m_w[i] <= (inc == 1);
        if (rel[i] && m_o[i] == 0) m_e[i] <= 1'b1;
        m_o[i] <= m_o[i] + inc - dec;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("i%0d out_cmd_valid", i), 32'(ov[i]), 32'(m_v[i]));
      if (m_v[i]) chk($sformatf("i%0d out_cmd_data", i), od[i], m_d[i]);
      chk($sformatf("i%0d out_wait", i), 32'(ow[i]), 32'(m_w[i]));
      chk($sformatf("i%0d out_outstanding", i), 32'(outs(i)), 32'(m_o[i]));
      chk($sformatf("i%0d out_blocked", i), 32'(ob[i]), 32'(m_o[i] == maxa(i)));
      chk($sformatf("i%0d out_error", i), 32'(oe[i]), 32'(m_e[i]));
      chk($sformatf("i%0d in_cmd_ready", i), 32'(ir[i]), 32'(m_rdy(i)));
      if (ow[i]) waits[i]++;
    end
    if (ov[0] && orr[0]) emit0.push_back(od[0]);
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic cyc(int n);
    repeat (n) tick();
  endtask

  task automatic send(int i, bit bar, logic [31:0] d);
    int n = 0;
    bit acc = 1'b0;
    iv[i] = 1'b1; ib[i] = bar; id[i] = d;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = ir[i];
      tick();
      n++;
    end
    iv[i] = 1'b0; ib[i] = 1'b0;
    if (!acc) chk($sformatf("i%0d send timeout", i), 32'd0, 32'd1);
  endtask

  task automatic all_zero(string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s i%0d valid", tag, i), 32'(ov[i]), 32'd0);
      chk($sformatf("%s i%0d data", tag, i), od[i], 32'd0);
      chk($sformatf("%s i%0d wait", tag, i), 32'(ow[i]), 32'd0);
      chk($sformatf("%s i%0d outstanding", tag, i), 32'(outs(i)), 32'd0);
      chk($sformatf("%s i%0d blocked", tag, i), 32'(ob[i]), 32'd0);
      chk($sformatf("%s i%0d error", tag, i), 32'(oe[i]), 32'd0);
    end
  endtask

  initial begin
    int w;
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0; ib[i] = 1'b0; id[i] = '0; orr[i] = 1'b0; rel[i] = 1'b0;
    end
    cyc(3);
    reset_n = 1'b1;
    @(negedge clk);
    all_zero("reset");
    tick();

    // data only, strict fence instance
    orr[0] = 1'b1;
    emit0.delete();
    w = waits[0];
    for (int k = 0; k < 8; k++) send(0, 1'b0, 32'h10 + 32'(k));
    cyc(2);
    chk("data count", 32'(emit0.size()), 32'd8);
    for (int k = 0; k < 8 && k < emit0.size(); k++)
      chk($sformatf("data order %0d", k), emit0[k], 32'h10 + 32'(k));
    chk("data no wait", 32'(waits[0] - w), 32'd0);

    // strict fence: A, barrier, B
    emit0.delete();
    send(0, 1'b0, 32'hA);
    send(0, 1'b1, 32'h0);
    @(negedge clk);
    chk("fence wait pulse", 32'(ow[0]), 32'd1);
    chk("fence outstanding", 32'(os0), 32'd1);
    chk("fence blocked", 32'(ob[0]), 32'd1);
    tick();
    iv[0] = 1'b1; ib[0] = 1'b0; id[0] = 32'hB;
    repeat (4) begin
      @(negedge clk);
      chk("fence B stalled", 32'(ir[0]), 32'd0);
      tick();
    end
    chk("fence only A out", 32'(emit0.size()), 32'd1);
    if (emit0.size() > 0) chk("fence A data", emit0[0], 32'hA);
    rel[0] = 1'b1;
    tick();
    rel[0] = 1'b0;
    send(0, 1'b0, 32'hB);
    cyc(2);
    chk("fence B out", 32'(emit0.size()), 32'd2);
    if (emit0.size() > 1) chk("fence B data", emit0[1], 32'hB);

    // fence drain: barrier waits behind a held command
    orr[0] = 1'b0;
    send(0, 1'b0, 32'hC);
    iv[0] = 1'b1; ib[0] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("drain barrier stalled", 32'(ir[0]), 32'd0);
      tick();
    end
    orr[0] = 1'b1;
    w = waits[0];
    send(0, 1'b1, 32'h0);
    cyc(2);
    chk("drain wait pulse", 32'(waits[0] - w), 32'd1);
    rel[0] = 1'b1;
    tick();
    rel[0] = 1'b0;
    cyc(2);

    // release with nothing outstanding
    rel[0] = 1'b1;
    tick();
    rel[0] = 1'b0;
    @(negedge clk);
    chk("error set", 32'(oe[0]), 32'd1);
    chk("error count held", 32'(os0), 32'd0);
    cyc(3);
    @(negedge clk);
    chk("error sticky", 32'(oe[0]), 32'd1);
    tick();

    // run-ahead, MAX_AHEAD=3
    orr[1] = 1'b1;
    w = waits[1];
    for (int k = 0; k < 3; k++) begin
      send(1, 1'b0, 32'h20 + 32'(k));
      send(1, 1'b1, 32'h0);
    end
    cyc(2);
    @(negedge clk);
    chk("ahead outstanding 3", 32'(os1), 32'd3);
    chk("ahead blocked", 32'(ob[1]), 32'd1);
    chk("ahead wait pulses", 32'(waits[1] - w), 32'd3);
    chk("ahead ready low", 32'(ir[1]), 32'd0);
    tick();
    rel[1] = 1'b1;
    tick();
    rel[1] = 1'b0;
    @(negedge clk);
    chk("ahead outstanding 2", 32'(os1), 32'd2);
    chk("ahead unblocked", 32'(ob[1]), 32'd0);
    chk("ahead ready back", 32'(ir[1]), 32'd1);
    tick();
    iv[1] = 1'b1; ib[1] = 1'b1; rel[1] = 1'b1;
    @(negedge clk);
    chk("simul ready", 32'(ir[1]), 32'd1);
    tick();
    iv[1] = 1'b0; ib[1] = 1'b0; rel[1] = 1'b0;
    @(negedge clk);
    chk("simul count", 32'(os1), 32'd2);
    chk("simul wait", 32'(ow[1]), 32'd1);
    tick();
    rel[1] = 1'b1;
    cyc(2);
    rel[1] = 1'b0;
    @(negedge clk);
    chk("ahead drained", 32'(os1), 32'd0);
    tick();

    // randomized traffic on both instances
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 2; i++) begin
        iv[i]  = 1'($urandom_range(0, 1));
        ib[i]  = ($urandom_range(0, 3) == 0);
        id[i]  = $urandom;
        orr[i] = ($urandom_range(0, 3) != 0);
        rel[i] = ($urandom_range(0, 7) == 0);
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0; ib[i] = 1'b0; rel[i] = 1'b0; orr[i] = 1'b0;
    end
    tick();
    @(negedge clk);
    chk("error held before reset", 32'(oe[0]), 32'd1);
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    chk("error cleared by reset", 32'(oe[0]), 32'd0);
    tick();

    // async reset with outstanding=2 and a held command
    send(1, 1'b1, 32'h0);
    send(1, 1'b1, 32'h0);
    send(1, 1'b0, 32'h55);
    @(negedge clk);
    chk("pre-reset outstanding", 32'(os1), 32'd2);
    chk("pre-reset slot full", 32'(ov[1]), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    all_zero("async");
    @(posedge clk); #2;
    reset_n = 1'b1;
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
